mmapper_ext: RTL and testbench
==============================

Name: mmapper_ext

Overview:
- Parametrised MSX memory mapper that succeeds the fixed 4×8-bit mapper.
- Segment register width, I/O port base, external memory base and readback mode are configurable.
- Adds an external-memory request/acknowledge handshake with Z80 wait-state generation.
- Sits between the cartridge slot bus decode and the SDRAM/PSRAM arbiter.

Parameters:
- SEG_BITS, 8, segment register width, legal range 1..8; selects 2^SEG_BITS × 16 KB segments.
- IO_BASE, 8'hFC, base of the 4 consecutive mapper I/O ports; bits [1:0] ignored.
- MEM_BASE, 23'h020000, external memory byte offset of segment 0.
- ADDR_W, 23, external memory address width.
- RB_ONES, 1, readback fill: 1 = unused upper bits read as 1, 0 = read as 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  mapper enable; 0 = block fully inert except register state
- addr  in  16  Z80 address
- cdin  in  8  Z80 write data
- cdout  out  8  readback data
- busreq  out  1  drive cdout onto Z80 data bus
- sltsl_n  in  1  slot select, active low
- iorq_n, m1_n, rd_n, mreq_n, wr_n  in  1 each  Z80 strobes, active low
- mem_addr  out  ADDR_W  external memory address, latched at request
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_ack  in  1  one-cycle completion pulse from arbiter
- wait_n  out  1  Z80 WAIT, active low
- cart_ena  out  1  slot memory cycle active

Behaviour:
- Reset values:
  - seg[i] = 3-i, truncated to SEG_BITS.
  - cdout = 8'hFF if RB_ONES=1, else 8'h00.
  - busreq = 0, mem_req = 0, mem_we = 0, mem_addr = 0, wait_n = 1.
  - FSM = IDLE; strobe history = inactive.
- I/O decode: io_hit = enable & ~iorq_n & m1_n & (addr[7:2] == IO_BASE[7:2]).
- Register write:
  - Fires on the first clk where io_hit & ~wr_n is true after being false (edge detect on registered previous value).
  - Exactly one write per bus cycle.
  - seg[addr[1:0]] <= cdin[SEG_BITS-1:0].
- Register read:
  - While io_hit & ~rd_n: cdout registered each clk = {fill, seg[addr[1:0]]}, where fill is all 1 or all 0 per RB_ONES; busreq = 1, registered (1-cycle latency).
  - busreq drops the clk after the condition clears or enable falls.
- Mapping:
  - mem_addr_next = MEM_BASE + {seg[addr[15:14]], addr[13:0]}, zero-extended to ADDR_W.
  - The sum wraps modulo 2^ADDR_W.
- cart_ena = ~mreq_n & ~sltsl_n & iorq_n & enable (combinational).
- mem_go = cart_ena & (~rd_n | ~wr_n). Refresh (mreq_n low, rd_n and wr_n high) never starts a request.
- Memory FSM:
  - IDLE: on mem_go go to REQ. In the same clk, latch mem_addr = mem_addr_next and mem_we = ~wr_n; wait_n <= 0.
  - REQ: mem_req = 1; hold until mem_ack, then go to DONE with mem_req <= 0 and wait_n <= 1.
  - DONE: hold until mreq_n = 1, then go to IDLE. This prevents a second request within one bus cycle.
  - mem_ack in IDLE or DONE: ignored.
  - mem_ack in the same clk mem_req first rises: accepted, giving a 1-cycle request.
  - enable falling in REQ: request completes normally (no abort); the transition to IDLE occurs after DONE.
- Write/read precedence: a register write and a memory cycle cannot coincide; iorq_n gates cart_ena.
- Reset mid-operation: async to IDLE; mem_req = 0 and wait_n = 1 immediately; registers return to reset values.
- Latency:
  - Strobe to wait_n low: 1 clk.
  - mem_ack to wait_n high: 1 clk.

Test Plan:
- Reset then a memory read at addr 16'h4000, SEG_BITS=8: mem_addr = 23'h020000 + {8'h02, 14'h0000} = 23'h028000; mem_we = 0; wait_n low until 1 clk after mem_ack.
- I/O write port 16'h00FD, data 8'h37, wr_n held 5 clks: exactly one update, seg[1] = 8'h37. Then a write to addr 16'h7FFF yields mem_addr = 23'h020000 + 23'h0DFFFF = 23'h0FFFFF, mem_we = 1.
- SEG_BITS=4, RB_ONES=1: write 8'hA5 to port 16'h00FE; read it back: cdout = 8'hF5, busreq = 1 one clk after rd_n falls, and 0 one clk after rd_n rises. RB_ONES=0 gives 8'h05.
- Refresh cycle (mreq_n = 0, rd_n = wr_n = 1, sltsl_n = 0): mem_req stays 0, wait_n stays 1. enable = 0 during a port 16'h00FC write: seg[0] unchanged, busreq = 0.
- mem_ack held off 10 clks: mem_req and wait_n low are held 10 clks. reset_n asserted in clk 5 of REQ: mem_req = 0 and wait_n = 1 asynchronously, seg[0] = 3.
- MEM_BASE = 23'h7F0000, seg = 8'hFF, addr 16'h0000: mem_addr = 23'h02C000, wrapped modulo 2^23.

Source files
------------

// File: rtl/mmapper_ext.sv
// MSX memory mapper: four segment registers on I/O ports, external-memory request/ack with Z80 WAIT.
// Strobe to wait_n low is 1 clk, mem_ack to wait_n high is 1 clk; a request is held until the arbiter acks.
module mmapper_ext #(
  parameter int unsigned        SEG_BITS = 8,
  parameter logic [7:0]         IO_BASE  = 8'hFC,
  parameter int unsigned        ADDR_W   = 23,
  parameter logic [ADDR_W-1:0]  MEM_BASE = ADDR_W'(23'h020000),
  parameter bit                 RB_ONES  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [15:0]       addr,
  input  logic [7:0]        cdin,
  output logic [7:0]        cdout,
  output logic              busreq,
  input  logic              sltsl_n,
  input  logic              iorq_n,
  input  logic              m1_n,
  input  logic              rd_n,
  input  logic              mreq_n,
  input  logic              wr_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              wait_n,
  output logic              cart_ena
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  localparam logic [7:0] SEG_MASK  = 8'hFF >> (8 - SEG_BITS);
  localparam logic [7:0] RB_FILL   = RB_ONES ? ~SEG_MASK : 8'h00;
  localparam logic [7:0] CDOUT_RST = RB_ONES ? 8'hFF : 8'h00;

  logic [SEG_BITS-1:0] seg_q [4];
  logic [SEG_BITS-1:0] seg_d [4];
  logic                wr_prev_q, wr_prev_d;
  logic [7:0]          cdout_q, cdout_d;
  logic                busreq_q, busreq_d;
  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                wait_n_q, wait_n_d;

  logic                io_hit, io_wr, io_rd, mem_go;
  logic [SEG_BITS-1:0] seg_map;
  logic [ADDR_W-1:0]   mem_addr_next;

  always_comb begin
    io_hit   = enable & ~iorq_n & m1_n & (addr[7:2] == IO_BASE[7:2]);
    io_wr    = io_hit & ~wr_n;
    io_rd    = io_hit & ~rd_n;
    cart_ena = ~mreq_n & ~sltsl_n & iorq_n & enable;
    mem_go   = cart_ena & (~rd_n | ~wr_n);

    // Offset wraps naturally at ADDR_W bits.
    seg_map       = seg_q[addr[15:14]];
    mem_addr_next = MEM_BASE + ADDR_W'({seg_map, addr[13:0]});

    // Only the leading edge of a port write updates the register.
    seg_d     = seg_q;
    wr_prev_d = io_wr;
    if (io_wr && !wr_prev_q) begin
      seg_d[addr[1:0]] = cdin[SEG_BITS-1:0];
    end

    busreq_d = io_rd;
    cdout_d  = cdout_q;
    if (io_rd) begin
      cdout_d = RB_FILL | 8'(seg_q[addr[1:0]]);
    end

    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    wait_n_d   = wait_n_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_go) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr_next;
          mem_we_d   = ~wr_n;
          wait_n_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          wait_n_d  = 1'b1;
        end
      end
      ST_DONE: begin
        // Wait for the bus cycle to end so one cycle never issues two requests.
        if (mreq_n) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        wait_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        seg_q[i] <= SEG_BITS'(3 - i);
      end
      wr_prev_q  <= 1'b0;
      cdout_q    <= CDOUT_RST;
      busreq_q   <= 1'b0;
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wait_n_q   <= 1'b1;
    end else begin
      seg_q      <= seg_d;
      wr_prev_q  <= wr_prev_d;
      cdout_q    <= cdout_d;
      busreq_q   <= busreq_d;
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wait_n_q   <= wait_n_d;
    end
  end

  assign cdout    = cdout_q;
  assign busreq   = busreq_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign wait_n   = wait_n_q;

endmodule

// File: tb/tb_mmapper_ext.sv
// Bench for mmapper_ext: three parameterisations share one Z80 bus; a scoreboard checks requests and readback.
module tb_mmapper_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable;
  logic [15:0] addr;
  logic [7:0]  cdin;
  logic        sltsl_n, iorq_n, m1_n, rd_n, mreq_n, wr_n, mem_ack;

  logic [7:0]  cdout    [3];
  logic        busreq   [3];
  logic [22:0] mem_addr [3];
  logic        mem_req  [3];
  logic        mem_we   [3];
  logic        wait_n   [3];
  logic        cart_ena [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mmapper_ext #(
      .SEG_BITS ((g == 0) ? 8 : 4),
      .IO_BASE  (8'hFC),
      .ADDR_W   (23),
      .MEM_BASE ((g == 1) ? 23'h7F0000 : 23'h020000),
      .RB_ONES  ((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .addr(addr), .cdin(cdin),
      .cdout(cdout[g]), .busreq(busreq[g]), .sltsl_n(sltsl_n), .iorq_n(iorq_n),
      .m1_n(m1_n), .rd_n(rd_n), .mreq_n(mreq_n), .wr_n(wr_n),
      .mem_addr(mem_addr[g]), .mem_req(mem_req[g]), .mem_we(mem_we[g]),
      .mem_ack(mem_ack), .wait_n(wait_n[g]), .cart_ena(cart_ena[g])
    );
  end

  // Reference model: parameters per instance and the four segment values.
  int sb [3] = '{8, 4, 4};
  int rb [3] = '{1, 1, 0};
  int mb [3] = '{32'h020000, 32'h7F0000, 32'h020000};
  int segm [3][4];

  typedef struct packed {
    logic [2:0][22:0] a;
    logic             we;
  } mexp_t;
  typedef logic [2:0][7:0] rexp_t;

  mexp_t mq[$];
  rexp_t rq[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int seg_mask(int k);
    return (1 << sb[k]) - 1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++)
        segm[k][i] = (3 - i) & seg_mask(k);
  endfunction

  function automatic logic [22:0] exp_addr(int k, logic [15:0] a);
    int off;
    off = (segm[k][a[15:14]] << 14) + int'(a[13:0]);
    return 23'((mb[k] + off) % (1 << 23));
  endfunction

  function automatic logic [7:0] exp_rb(int k, logic [1:0] p);
    int v;
    v = segm[k][p];
    if (rb[k] != 0) v = v + (255 - seg_mask(k));
    return 8'(v);
  endfunction

  // Monitor: pop expectations whenever a request or a readback appears.
  logic prev_req = 1'b0;
  logic prev_bus = 1'b0;
  always @(negedge clk) begin
    mexp_t me;
    rexp_t re;
    if (mem_req[0] && !prev_req) begin
      if (mq.size() == 0) chk("mem_req_unexpected", 1, 0);
      else begin
        me = mq.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk("mem_req_all", mem_req[k], 1);
          chk("mem_addr", mem_addr[k], me.a[k]);
          chk("mem_we", mem_we[k], me.we);
        end
      end
    end
    if (busreq[0] && !prev_bus) begin
      if (rq.size() == 0) chk("busreq_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk("busreq_all", busreq[k], 1);
          chk("cdout", cdout[k], re[k]);
        end
      end
    end
    prev_req = mem_req[0];
    prev_bus = busreq[0];
  end

  task automatic idle_bus();
    iorq_n = 1; mreq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; sltsl_n = 1; mem_ack = 0;
  endtask

  task automatic io_write(input logic [15:0] port, input logic [7:0] d, input int hold);
    if (enable && port[7:2] == 6'h3F)
      for (int k = 0; k < 3; k++) segm[k][port[1:0]] = int'(d) & seg_mask(k);
    @(posedge clk); #1;
    addr = port; cdin = d; iorq_n = 0; wr_n = 0;
    @(posedge clk); #1;
    cdin = ~d;  // later cycles of the same write must not land
    repeat (hold - 1) begin @(posedge clk); #1; end
    iorq_n = 1; wr_n = 1;
  endtask

  task automatic io_read(input logic [15:0] port, input int hold);
    rexp_t e;
    bit hit;
    hit = enable && (port[7:2] == 6'h3F);
    if (hit) begin
      for (int k = 0; k < 3; k++) e[k] = exp_rb(k, port[1:0]);
      rq.push_back(e);
    end
    @(posedge clk); #1;
    addr = port; iorq_n = 0; rd_n = 0;
    @(negedge clk);
    chk("busreq_before_edge", busreq[0], 0);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("busreq_rise", busreq[k], hit);
    repeat (hold - 1) @(posedge clk);
    #1;
    iorq_n = 1; rd_n = 1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("busreq_fall", busreq[k], 0);
  endtask

  task automatic mem_cycle(input logic [15:0] a, input bit we, input int dly, input bit drop_en);
    mexp_t e;
    int n;
    for (int k = 0; k < 3; k++) e.a[k] = exp_addr(k, a);
    e.we = we;
    mq.push_back(e);
    @(posedge clk); #1;
    addr = a; cdin = 8'($urandom); sltsl_n = 0; mreq_n = 0;
    if (we) wr_n = 0; else rd_n = 0;
    @(negedge clk);
    chk("cart_ena", cart_ena[0], 1);
    chk("wait_n_pre", wait_n[0], 1);
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (mem_req[0]) n++;
      chk("wait_n_hold", wait_n[0], 0);
      if (drop_en && i == 0) enable = 0;
      @(posedge clk); #1;
    end
    mem_ack = 1;
    @(negedge clk);
    if (mem_req[0]) n++;
    for (int k = 0; k < 3; k++) chk("wait_n_at_ack", wait_n[k], 0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("req_cycles", n, dly + 1);
    for (int k = 0; k < 3; k++) begin
      chk("mem_req_after_ack", mem_req[k], 0);
      chk("wait_n_after_ack", wait_n[k], 1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("no_second_req", mem_req[0], 0);
    #1;
    idle_bus();
    enable = 1;
    @(posedge clk); #1;
  endtask

  task automatic no_req(input bit rd_low, input bit slt_n);
    @(posedge clk); #1;
    sltsl_n = slt_n; mreq_n = 0; rd_n = !rd_low; mem_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("noreq_mem_req", mem_req[0], 0);
      chk("noreq_wait_n", wait_n[0], 1);
      #1 mem_ack = 0;
    end
    #1;
    idle_bus();
  endtask

  initial begin
    reset_n = 1; enable = 1; addr = 0; cdin = 0;
    idle_bus();
    model_reset();
    #1 reset_n = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_cdout", cdout[k], (rb[k] != 0) ? 8'hFF : 8'h00);
      chk("rst_busreq", busreq[k], 0);
      chk("rst_mem_req", mem_req[k], 0);
      chk("rst_mem_we", mem_we[k], 0);
      chk("rst_mem_addr", mem_addr[k], 0);
      chk("rst_wait_n", wait_n[k], 1);
    end
    @(posedge clk); #1 reset_n = 1;

    mem_cycle(16'h4000, 0, 2, 0);
    io_write(16'h00FD, 8'h37, 5);
    io_read(16'h00FD, 2);
    mem_cycle(16'h7FFF, 1, 0, 0);
    io_write(16'h00FE, 8'hA5, 1);
    io_read(16'h00FE, 3);
    no_req(0, 0);
    no_req(1, 1);
    enable = 0;
    io_write(16'h00FC, 8'h99, 2);
    io_read(16'h00FC, 2);
    enable = 1;
    io_read(16'h00FC, 1);
    mem_cycle(16'h1234, 0, 10, 0);
    mem_cycle(16'hC000, 1, 3, 1);
    io_write(16'h00FC, 8'hFF, 1);
    mem_cycle(16'h0000, 0, 0, 0);

    // Reset in the fifth clock of a held request.
    begin
      mexp_t e;
      for (int k = 0; k < 3; k++) e.a[k] = exp_addr(k, 16'h8123);
      e.we = 0;
      mq.push_back(e);
      @(posedge clk); #1;
      addr = 16'h8123; sltsl_n = 0; mreq_n = 0; rd_n = 0;
      repeat (5) @(posedge clk);
      #2;
      chk("req_held_before_reset", mem_req[0], 1);
      reset_n = 0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
        chk("arst_mem_req", mem_req[k], 0);
        chk("arst_wait_n", wait_n[k], 1);
      end
      idle_bus();
      @(posedge clk); #1 reset_n = 1;
      io_read(16'h00FC, 1);
    end

    for (int it = 0; it < 80; it++) begin
      logic [15:0] p;
      p = {8'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F, 2'($urandom)};
      case ($urandom_range(0, 3))
        0: io_write(p, 8'($urandom), $urandom_range(1, 3));
        1: io_read(p, $urandom_range(1, 3));
        default: mem_cycle(16'($urandom), 1'($urandom), $urandom_range(0, 4), 0);
      endcase
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mem_queue_drained", mq.size(), 0);
    chk("rb_queue_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
